zeroriscy_multdiv_ctrl: RTL and testbench

Issue-side controller for the slow iterative multiply/divide unit. It accepts one decoded MUL/DIV request at a time from the ID stage, drives the unit's enable/operator/operand inputs stable for the whole operation, and waits for the unit's `ready`. It then captures the result and presents it on a register-file writeback port with backpressure. It also handles pipeline flush, because the unit cannot be aborted, and runs a hang watchdog.

---
 rtl/zeroriscy_multdiv_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_zeroriscy_multdiv_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// zeroriscy_multdiv_ctrl
//
// Issue-side controller for the slow iterative multiply/divide unit. It takes
// one decoded MUL/DIV request at a time, holds the unit's enable, operator and
// operands stable until the unit reports ready, then presents the result on a
// register-file writeback port with backpressure. A flush cannot abort the
// unit, so a flushed op is drained to completion and its result dropped. A
// sticky watchdog flags a unit that never finishes.
//
// Parameters:
//   WDOG_LIMIT        cycles in ISSUE/DRAIN without md_ready_i before error_o
//                     is set (1..63)
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   req_*             decoded request (valid/ready handshake, div select,
//                     operator, signed mode, operands, destination register)
//   flush_i           kill the in-flight request
//   md_*_o            registered enables/operator/signed mode/operands to unit
//   md_result_i       unit result, valid while md_ready_i is high
//   md_ready_i        unit done
//   wb_valid_o/ready  writeback handshake; wb_rd_o/wb_data_o address and data
//   busy_o            controller not idle
//   last_latency_o    cycles of last completed op, saturating at 63
//   error_o           sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module zeroriscy_multdiv_ctrl #(
    parameter int unsigned WDOG_LIMIT = 63
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_div_i,
    input  logic [1:0]  req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic [4:0]  req_rd_i,

    input  logic        flush_i,

    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    input  logic [31:0] md_result_i,
    input  logic        md_ready_i,

    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,

    output logic        busy_o,
    output logic [5:0]  last_latency_o,
    output logic        error_o
);

    localparam logic [5:0] WDOG_LIMIT_W = 6'(WDOG_LIMIT);
    localparam logic [5:0] CNT_MAX      = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WB
    } state_e;

    state_e      state_q, state_d;

    logic        accept;      // request handshake this cycle
    logic        complete;    // unit finished and result is kept
    logic        release_en;  // unit finished; drop enables at this edge
    logic        waiting;     // ISSUE/DRAIN cycle without ready

    logic [5:0]  lat_cnt_q;   // ISSUE cycles elapsed before the current one
    logic [5:0]  wdog_cnt_q;  // ISSUE/DRAIN cycles without ready
    logic [5:0]  lat_inc;
    logic [5:0]  wdog_inc;

    assign lat_inc  = (lat_cnt_q  == CNT_MAX) ? CNT_MAX : lat_cnt_q  + 6'd1;
    assign wdog_inc = (wdog_cnt_q == CNT_MAX) ? CNT_MAX : wdog_cnt_q + 6'd1;

    assign busy_o = (state_q != S_IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake decode
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        wb_valid_o  = 1'b0;
        accept      = 1'b0;
        complete    = 1'b0;
        release_en  = 1'b0;
        waiting     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = ~flush_i;
                if (req_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (md_ready_i) begin
                    release_en = 1'b1;
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        complete = 1'b1;
                        // A write to x0 is dropped here rather than sent.
                        state_d  = (wb_rd_o != 5'd0) ? S_WB : S_IDLE;
                    end
                end else begin
                    waiting = 1'b1;
                    if (flush_i) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // The unit cannot be aborted; keep it enabled until it ends.
                if (md_ready_i) begin
                    release_en = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    waiting = 1'b1;
                end
            end

            S_WB: begin
                wb_valid_o = ~flush_i;
                if (flush_i || wb_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Unit drive, result capture, latency and watchdog registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_mult_en_o     <= 1'b0;
            md_div_en_o      <= 1'b0;
            md_operator_o    <= 2'b00;
            md_signed_mode_o <= 2'b00;
            md_op_a_o        <= 32'd0;
            md_op_b_o        <= 32'd0;
            wb_rd_o          <= 5'd0;
            wb_data_o        <= 32'd0;
            last_latency_o   <= 6'd0;
            error_o          <= 1'b0;
            lat_cnt_q        <= 6'd0;
            wdog_cnt_q       <= 6'd0;
        end else begin
            if (accept) begin
                md_mult_en_o     <= ~req_is_div_i;
                md_div_en_o      <= req_is_div_i;
                md_operator_o    <= req_operator_i;
                md_signed_mode_o <= req_signed_mode_i;
                md_op_a_o        <= req_op_a_i;
                md_op_b_o        <= req_op_b_i;
                wb_rd_o          <= req_rd_i;
            end else if (release_en) begin
                // Enables must be low the cycle after ready or the unit restarts.
                md_mult_en_o <= 1'b0;
                md_div_en_o  <= 1'b0;
            end

            if (complete) begin
                wb_data_o      <= md_result_i;
                last_latency_o <= lat_inc;  // includes the ready cycle
            end

            if (accept) begin
                lat_cnt_q <= 6'd0;
            end else if (state_q == S_ISSUE) begin
                lat_cnt_q <= lat_inc;
            end

            if (accept) begin
                wdog_cnt_q <= 6'd0;
            end else if (waiting) begin
                wdog_cnt_q <= wdog_inc;
                if (wdog_inc >= WDOG_LIMIT_W) begin
                    error_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zeroriscy_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zeroriscy_multdiv_ctrl
//
// Self-checking bench. A stub multiply/divide unit answers the DUT's enables
// with the expected slow-unit timing. Each op is driven from a timeline derived
// from the request (accept cycle, enabled cycles, ready cycle, writeback), and
// a single compare process checks every output against that timeline on each
// falling edge. A few directed ops also pin observed values to literals.
// -----------------------------------------------------------------------------
module tb_zeroriscy_multdiv_ctrl;

    localparam int WDOG = 63;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_is_div_i;
    logic [1:0]  req_operator_i;
    logic [1:0]  req_signed_mode_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        md_mult_en_o;
    logic        md_div_en_o;
    logic [1:0]  md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic [31:0] md_result_i;
    logic        md_ready_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o;
    logic [5:0]  last_latency_o;
    logic        error_o;

    zeroriscy_multdiv_ctrl #(.WDOG_LIMIT(WDOG)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_is_div_i      (req_is_div_i),
        .req_operator_i    (req_operator_i),
        .req_signed_mode_i (req_signed_mode_i),
        .req_op_a_i        (req_op_a_i),
        .req_op_b_i        (req_op_b_i),
        .req_rd_i          (req_rd_i),
        .flush_i           (flush_i),
        .md_mult_en_o      (md_mult_en_o),
        .md_div_en_o       (md_div_en_o),
        .md_operator_o     (md_operator_o),
        .md_signed_mode_o  (md_signed_mode_o),
        .md_op_a_o         (md_op_a_o),
        .md_op_b_o         (md_op_b_o),
        .md_result_i       (md_result_i),
        .md_ready_i        (md_ready_i),
        .wb_valid_o        (wb_valid_o),
        .wb_ready_i        (wb_ready_i),
        .wb_rd_o           (wb_rd_o),
        .wb_data_o         (wb_data_o),
        .busy_o            (busy_o),
        .last_latency_o    (last_latency_o),
        .error_o           (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic of the multiply/divide unit.
    function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] mode,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa;
        logic signed [32:0] sb;
        logic signed [65:0] p;
        logic               sdiv;
        sa   = {mode[0] & a[31], a};
        sb   = {mode[1] & b[31], b};
        sdiv = (mode == 2'b11);
        p    = sa * sb;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                if (sdiv) return $signed(a) / $signed(b);
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                if (sdiv) return $signed(a) % $signed(b);
                return a % b;
            end
        endcase
    endfunction

    // ------------------------------------------------------------- stub unit
    int stub_target_ovr = -1;  // >=0 forces the ready cycle (large = never)
    int stub_cnt;
    int stub_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stub_cnt <= 0;
        else if (md_mult_en_o || md_div_en_o) stub_cnt <= stub_cnt + 1;
        else stub_cnt <= 0;
    end

    always_comb begin
        stub_target = 32;
        md_ready_i  = 1'b0;
        md_result_i = 32'hDEAD_BEEF;
        if (stub_target_ovr >= 0) stub_target = stub_target_ovr;
        else if (md_div_en_o) stub_target = (md_op_b_o == 32'd0) ? 1 : 36;
        if ((md_mult_en_o || md_div_en_o) && stub_cnt == stub_target) begin
            md_ready_i  = 1'b1;
            md_result_i = md_ref(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
        end
    end

    // ------------------------------------------------- expected-output model
    logic        chk_on = 1'b0;
    logic        e_req_ready = 1'b0, e_busy = 1'b0, e_wb_valid = 1'b0;
    logic        e_mult_en = 1'b0, e_div_en = 1'b0, e_err = 1'b0;
    logic        e_md_chk = 1'b0, e_wb_chk = 1'b0;
    logic [1:0]  e_op = '0, e_mode = '0;
    logic [31:0] e_a = '0, e_b = '0, e_data = '0;
    logic [4:0]  e_rd = '0;
    logic [5:0]  e_lat = '0;
    logic [5:0]  m_lat = '0;   // last completed latency
    logic        m_err = 1'b0; // sticky watchdog

    int          obs_wb_c, obs_writes, obs_valid;
    logic [31:0] obs_data;

    always @(negedge clk) begin
        if (chk_on) begin
            check("req_ready", req_ready_o, e_req_ready);
            check("busy", busy_o, e_busy);
            check("wb_valid", wb_valid_o, e_wb_valid);
            check("mult_en", md_mult_en_o, e_mult_en);
            check("div_en", md_div_en_o, e_div_en);
            check("last_latency", last_latency_o, e_lat);
            check("error", error_o, e_err);
            if (e_md_chk) begin
                check("md_operator", md_operator_o, e_op);
                check("md_signed_mode", md_signed_mode_o, e_mode);
                check("md_op_a", md_op_a_o, e_a);
                check("md_op_b", md_op_b_o, e_b);
            end
            if (e_wb_chk) begin
                check("wb_rd", wb_rd_o, e_rd);
                check("wb_data", wb_data_o, e_data);
            end
        end
    end

    task automatic idle_exp();
        e_req_ready = ~flush_i; e_busy = 1'b0; e_wb_valid = 1'b0;
        e_mult_en = 1'b0; e_div_en = 1'b0; e_md_chk = 1'b0; e_wb_chk = 1'b0;
        e_lat = m_lat; e_err = m_err;
    endtask

    task automatic reset_seq(input int cycles);
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
        m_lat = '0; m_err = 1'b0;
        idle_exp();
        e_md_chk = 1'b1; e_op = '0; e_mode = '0; e_a = '0; e_b = '0;
        e_wb_chk = 1'b1; e_rd = '0; e_data = '0;
        chk_on = 1'b1;
        repeat (cycles) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Idle cycles; with flush_mode a request is held valid under flush and
    // must not be taken.
    task automatic idle(input int n, input logic flush_mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            flush_i     = flush_mode & 1'($urandom % 2);
            req_valid_i = flush_i;
            req_op_a_i  = $urandom;
            req_rd_i    = 5'($urandom);
            wb_ready_i  = 1'($urandom % 2);
            idle_exp();
        end
    endtask

    // One op: c counts cycles from the accept cycle (c=0); enabled cycle k is
    // c-1; the unit is ready at k=R; writeback (if any) starts at c=R+2.
    task automatic run_op(input logic is_div, input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int flush_c, input int stall, input int ovr, input int max_c);
        int          r, k, w;
        logic [31:0] res;
        logic        flushed, done;
        r   = (ovr >= 0) ? ovr : (is_div ? ((b == 32'd0) ? 1 : 36) : 32);
        res = md_ref(op, mode, a, b);
        stub_target_ovr = ovr;
        flushed = 1'b0; done = 1'b0;
        obs_wb_c = -1; obs_writes = 0; obs_valid = 0; obs_data = '0;
        for (int c = 0; c < max_c && !done; c++) begin
            @(posedge clk); #1;
            flush_i     = (c == flush_c);
            req_valid_i = (c == 0);
            wb_ready_i  = 1'b0;
            if (c == 0) begin
                req_is_div_i = is_div; req_operator_i = op; req_signed_mode_i = mode;
                req_op_a_i = a; req_op_b_i = b; req_rd_i = rd;
            end else begin
                req_is_div_i = 1'($urandom); req_operator_i = 2'($urandom);
                req_op_a_i = $urandom; req_op_b_i = $urandom; req_rd_i = 5'($urandom);
            end
            idle_exp();
            if (c == 0) begin
                e_req_ready = 1'b1;
            end else if (c <= r + 1) begin
                k = c - 1;
                e_req_ready = 1'b0; e_busy = 1'b1;
                e_mult_en = ~is_div; e_div_en = is_div;
                e_md_chk = 1'b1; e_op = op; e_mode = mode; e_a = a; e_b = b;
                if (k >= WDOG) m_err = 1'b1;
                e_err = m_err;
                if (flush_i) flushed = 1'b1;
                if (k == r) begin
                    if (!flushed) begin
                        m_lat = (r + 1 > 63) ? 6'd63 : 6'(r + 1);
                        if (rd == 5'd0) done = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end
            end else begin
                w = c - (r + 2);
                wb_ready_i  = (w >= stall);
                e_req_ready = 1'b0; e_busy = 1'b1;
                e_wb_valid  = ~flush_i;
                e_wb_chk = 1'b1; e_rd = rd; e_data = res;
                if (flush_i || wb_ready_i) done = 1'b1;
            end
            @(negedge clk);
            if (wb_valid_o) begin
                obs_valid++;
                if (obs_wb_c < 0) begin
                    obs_wb_c = c - 1;
                    obs_data = wb_data_o;
                end
                if (wb_ready_i) obs_writes++;
            end
        end
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        logic        is_div;
        logic [1:0]  op;
        logic [31:0] b;
        int          r, st, fc;

        rst_n = 1'b0; req_valid_i = 1'b0; req_is_div_i = 1'b0; req_operator_i = '0;
        req_signed_mode_i = '0; req_op_a_i = '0; req_op_b_i = '0; req_rd_i = '0;
        flush_i = 1'b0; wb_ready_i = 1'b0;

        reset_seq(2);
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_wb_data", wb_data_o, 32'd0);

        // MUL 7 * -3, signed, rd=5
        run_op(1'b0, 2'd0, 2'b11, 32'd7, 32'hFFFF_FFFD, 5'd5, -1, 0, -1, 100);
        check("mul_data", obs_data, 32'hFFFF_FFEB);
        check("mul_wb_cycle", obs_wb_c, 33);
        check("mul_latency", last_latency_o, 6'd33);
        idle(2, 1'b0);

        // DIVU by zero
        run_op(1'b1, 2'd2, 2'b00, 32'd100, 32'd0, 5'd3, -1, 0, -1, 100);
        check("divz_data", obs_data, 32'hFFFF_FFFF);
        check("divz_latency", last_latency_o, 6'd2);

        // DIV -7/2 signed with 5 cycles of writeback stall
        run_op(1'b1, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd9, -1, 5, -1, 100);
        check("div_data", obs_data, 32'hFFFF_FFFD);
        check("div_wb_cycle", obs_wb_c, 37);
        check("div_writes", obs_writes, 1);
        check("div_valid_cycles", obs_valid, 6);
        idle(3, 1'b1);

        // Flush 10 cycles into a DIV
        run_op(1'b1, 2'd2, 2'b11, 32'd1000, 32'd7, 5'd4, 11, 0, -1, 100);
        check("flush_no_valid", obs_valid, 0);
        check("flush_latency_kept", last_latency_o, 6'd37);

        // rd=0 MUL then back-to-back DIV
        run_op(1'b0, 2'd1, 2'b01, 32'h8000_0001, 32'd5, 5'd0, -1, 0, -1, 100);
        check("rd0_no_write", obs_valid, 0);
        run_op(1'b1, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd12, -1, 1, -1, 100);
        check("b2b_rem_data", obs_data, 32'hFFFF_FFFF);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            is_div = 1'($urandom % 2);
            op     = {is_div, 1'($urandom % 2)};
            b      = ($urandom % 6 == 0) ? 32'd0 : (($urandom % 3 == 0) ? 32'($urandom % 16) : $urandom);
            r      = is_div ? ((b == 32'd0) ? 1 : 36) : 32;
            st     = $urandom % 4;
            fc     = ($urandom % 4 == 0) ? 1 + int'($urandom % 32'(r + 4 + st)) : -1;
            run_op(is_div, op, 2'($urandom), $urandom, b,
                   ($urandom % 5 == 0) ? 5'd0 : 5'($urandom), fc, st, -1, 200);
            idle($urandom % 3, 1'($urandom % 2));
        end

        // Unit that never finishes: watchdog, then reset mid-op
        run_op(1'b0, 2'd0, 2'b00, 32'd3, 32'd4, 5'd1, -1, 0, 1000, 80);
        check("wdog_error", error_o, 1'b1);
        check("wdog_busy", busy_o, 1'b1);
        reset_seq(2);
        check("rst_error_clear", error_o, 1'b0);
        check("rst_mult_en", md_mult_en_o, 1'b0);

        // Very slow op: latency saturates and the watchdog fires on the way
        run_op(1'b0, 2'd0, 2'b11, 32'd6, 32'd7, 5'd7, -1, 0, 70, 120);
        check("slow_data", obs_data, 32'd42);
        check("slow_latency_sat", last_latency_o, 6'd63);
        idle(4, 1'b0);
        check("slow_error_sticky", error_o, 1'b1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
